// File: rtl/simd_execute_stage.sv
// rtl/simd_execute_stage.sv - two-stage lane-wise SIMD execute/writeback stage
//
// Purpose: accepts one vector instruction per cycle, reads two operands from
// an 8x32 register file, computes a lane-wise result over LANES unsigned
// LANE_W-bit lanes in a two-register pipeline (E1 operands, E2 result) and
// drives the register file write port. A RAW interlock holds issue while a
// source register is the destination of an instruction still in E1 or E2.
//
// Build option: SIMD_SAT_EN - ADD/MUL saturate at all-ones and SUB at zero
// per lane; when undefined ADD/SUB/MUL wrap modulo 2^LANE_W per lane.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   instr_valid/ready instruction handshake (opcode, rd, rs_a, rs_b, imm)
//   addr_a, addr_b    register file read addresses (pass-through of rs_a/rs_b)
//   vec_a, vec_b      register file read data (combinational read)
//   write_enable      one-cycle write strobe per instruction
//   write_addr/data   register file write address and data
//   retired_count     number of completed writebacks, wrapping
module simd_execute_stage #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [2:0]                opcode,
  input  logic [ADDR_W-1:0]         rd,
  input  logic [ADDR_W-1:0]         rs_a,
  input  logic [ADDR_W-1:0]         rs_b,
  input  logic [LANE_W-1:0]         imm,
  output logic [ADDR_W-1:0]         addr_a,
  output logic [ADDR_W-1:0]         addr_b,
  input  logic [LANES*LANE_W-1:0]   vec_a,
  input  logic [LANES*LANE_W-1:0]   vec_b,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [LANES*LANE_W-1:0]   write_data,
  output logic [CNT_W-1:0]          retired_count
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_MUL   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_MAX   = 3'b110,
    OP_BCAST = 3'b111
  } op_e;

  // E1: captured operands
  logic                     e1_valid_q;
  op_e                      e1_op_q;
  logic [ADDR_W-1:0]        e1_rd_q;
  logic [LANES*LANE_W-1:0]  e1_a_q, e1_b_q;
  logic [LANE_W-1:0]        e1_imm_q;

  // E2: registered result, drives the write port directly
  logic                     e2_valid_q;
  logic [ADDR_W-1:0]        e2_rd_q;
  logic [LANES*LANE_W-1:0]  e2_data_q;
  logic [LANES*LANE_W-1:0]  e2_data_d;

  logic [CNT_W-1:0]         count_q;
  logic                     hit_e1, hit_e2, accept;

  assign addr_a = rs_a;
  assign addr_b = rs_b;

  // A source matching an in-flight destination would read a stale value,
  // because the register file only commits when E2 retires.
  assign hit_e1 = e1_valid_q && ((rs_a == e1_rd_q) || (rs_b == e1_rd_q));
  assign hit_e2 = e2_valid_q && ((rs_a == e2_rd_q) || (rs_b == e2_rd_q));
  assign instr_ready = !(instr_valid && (opcode != OP_BCAST) && (hit_e1 || hit_e2));
  assign accept = instr_valid && instr_ready;

  always_comb begin
    logic [LANE_W-1:0] a, b, lane;
`ifdef SIMD_SAT_EN
    logic [LANE_W:0]     sum;
    logic [2*LANE_W-1:0] prod;
`endif
    e2_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      a    = e1_a_q[i*LANE_W +: LANE_W];
      b    = e1_b_q[i*LANE_W +: LANE_W];
      lane = '0;
`ifdef SIMD_SAT_EN
      sum  = {1'b0, a} + {1'b0, b};
      prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
`endif
      unique case (e1_op_q)
`ifdef SIMD_SAT_EN
        OP_ADD:   lane = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
        OP_SUB:   lane = (a < b) ? '0 : (a - b);
        OP_MUL:   lane = (|prod[2*LANE_W-1:LANE_W]) ? '1 : prod[LANE_W-1:0];
`else
        OP_ADD:   lane = a + b;
        OP_SUB:   lane = a - b;
        OP_MUL:   lane = a * b;
`endif
        OP_AND:   lane = a & b;
        OP_OR:    lane = a | b;
        OP_XOR:   lane = a ^ b;
        OP_MAX:   lane = (a > b) ? a : b;
        OP_BCAST: lane = e1_imm_q;
        default:  lane = '0;
      endcase
      e2_data_d[i*LANE_W +: LANE_W] = lane;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e1_op_q    <= OP_ADD;
      e1_rd_q    <= '0;
      e1_a_q     <= '0;
      e1_b_q     <= '0;
      e1_imm_q   <= '0;
      e2_valid_q <= 1'b0;
      e2_rd_q    <= '0;
      e2_data_q  <= '0;
      count_q    <= '0;
    end else begin
      e1_valid_q <= accept;
      if (accept) begin
        e1_op_q  <= op_e'(opcode);
        e1_rd_q  <= rd;
        e1_a_q   <= vec_a;
        e1_b_q   <= vec_b;
        e1_imm_q <= imm;
      end
      e2_valid_q <= e1_valid_q;
      if (e1_valid_q) begin
        e2_rd_q   <= e1_rd_q;
        e2_data_q <= e2_data_d;
      end
      if (e2_valid_q) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign write_enable  = e2_valid_q;
  assign write_addr    = e2_rd_q;
  assign write_data    = e2_data_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_simd_execute_stage.sv
// tb/tb_simd_execute_stage.sv - scoreboard bench for simd_execute_stage
module tb_simd_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  opcode = 3'd0;
  logic [2:0]  rd = 3'd0, rs_a = 3'd0, rs_b = 3'd0;
  logic [7:0]  imm = 8'd0;
  logic [2:0]  addr_a, addr_b;
  logic [31:0] vec_a, vec_b;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [31:0] write_data;
  logic [15:0] retired_count;

  simd_execute_stage dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs_a(rs_a), .rs_b(rs_b), .imm(imm),
    .addr_a(addr_a), .addr_b(addr_b), .vec_a(vec_a), .vec_b(vec_b),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Register file the stage is paired with: combinational read, posedge write.
  logic [31:0] rf [8] = '{default: 32'h0};
  always @(posedge clk) if (write_enable) rf[write_addr] <= write_data;
  assign vec_a = rf[addr_a];
  assign vec_b = rf[addr_b];

  // Architectural reference state, updated in program order at issue.
  logic [31:0] ref_rf [8] = '{default: 32'h0};
  logic [31:0] ref_save [8];

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [7:0] im);
    logic [31:0] res;
    int x, y, r;
    res = 32'h0;
    for (int i = 0; i < 4; i++) begin
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      case (op)
`ifdef SIMD_SAT_EN
        3'd0: r = (x + y > 255) ? 255 : x + y;
        3'd1: r = (x - y < 0) ? 0 : x - y;
        3'd2: r = (x * y > 255) ? 255 : x * y;
`else
        3'd0: r = (x + y) % 256;
        3'd1: r = (x - y + 256) % 256;
        3'd2: r = (x * y) % 256;
`endif
        3'd3: r = x & y;
        3'd4: r = x | y;
        3'd5: r = x ^ y;
        3'd6: r = (x > y) ? x : y;
        default: r = int'(im);
      endcase
      res[8*i +: 8] = r[7:0];
    end
    return res;
  endfunction

  // Must be called at a negedge; returns at a negedge.
  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [7:0] im, output int stalls);
    logic acc;
    exp_t e;
    stalls = 0;
    acc = 1'b0;
    instr_valid = 1'b1; opcode = op; rd = d; rs_a = a; rs_b = b; imm = im;
    for (int t = 0; t < 20; t++) begin
      #1 acc = instr_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      stalls++;
    end
    instr_valid = 1'b0;
    if (!acc) begin
      check("issue_timeout", 32'(stalls), 32'd0);
    end else begin
      e.rd   = d;
      e.data = model(op, ref_rf[a], ref_rf[b], im);
      e.cyc  = cyc;
      ref_rf[d] = e.data;
      exp_q.push_back(e);
      issued++;
    end
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("retired_count", {16'h0, retired_count}, {16'h0, 16'(issued)});
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (write_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {29'h0, write_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_addr", {29'h0, write_addr}, {29'h0, e.rd});
        check("write_data", write_data, e.data);
        check("latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2;
    logic [2:0] op, d, a, b;

    // 1. reset and two broadcasts
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_write_enable", {31'h0, write_enable}, 32'h0);
    check("rst_write_addr", {29'h0, write_addr}, 32'h0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_count", {16'h0, retired_count}, 32'h0);
    check("rst_ready", {31'h0, instr_ready}, 32'h1);
    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h03, s);
    issue(3'd7, 3'd2, 3'd0, 3'd0, 8'h05, s);
    drain();
    check("t1_count", {16'h0, retired_count}, 32'd2);
    check("t1_r1", rf[1], 32'h03030303);
    check("t1_r2", rf[2], 32'h05050505);

    // 2. independent back-to-back
    issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, s);
    issue(3'd5, 3'd4, 3'd1, 3'd2, 8'h00, s2);
    check("t2_stalls", 32'(s + s2), 32'd0);
    drain();
    check("t2_r3", rf[3], 32'h08080808);
    check("t2_r4", rf[4], 32'h06060606);

    // 3. RAW dependency stalls two cycles
    issue(3'd0, 3'd5, 3'd1, 3'd2, 8'h00, s);
    issue(3'd1, 3'd6, 3'd5, 3'd1, 8'h00, s2);
    check("t3_stalls", 32'(s2), 32'd2);
    drain();
    check("t3_r5", rf[5], 32'h08080808);
    check("t3_r6", rf[6], 32'h05050505);

    // 4. overflow / underflow
    issue(3'd7, 3'd7, 3'd0, 3'd0, 8'hF0, s);
    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h20, s);
    issue(3'd0, 3'd0, 3'd7, 3'd1, 8'h00, s);
    drain();
`ifdef SIMD_SAT_EN
    check("t4_add", rf[0], 32'hFFFFFFFF);
`else
    check("t4_add", rf[0], 32'h10101010);
`endif
    issue(3'd1, 3'd0, 3'd1, 3'd7, 8'h00, s);
    drain();
`ifdef SIMD_SAT_EN
    check("t4_sub", rf[0], 32'h00000000);
`else
    check("t4_sub", rf[0], 32'h30303030);
`endif

    // 5. multiply overflow and max
    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h10, s);
    issue(3'd2, 3'd2, 3'd1, 3'd1, 8'h00, s);
    issue(3'd7, 3'd3, 3'd0, 3'd0, 8'h03, s);
    issue(3'd7, 3'd4, 3'd0, 3'd0, 8'h05, s);
    issue(3'd6, 3'd5, 3'd3, 3'd4, 8'h00, s);
    drain();
`ifdef SIMD_SAT_EN
    check("t5_mul", rf[2], 32'hFFFFFFFF);
`else
    check("t5_mul", rf[2], 32'h00000000);
`endif
    check("t5_max", rf[5], 32'h05050505);

    // randomized traffic with idle gaps
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = 3'($urandom_range(0, 7));
      a  = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(op, d, a, b, 8'($urandom), s);
      if (s > 2) check("rand_stall_bound", 32'(s), 32'd2);
    end
    drain();
    for (int r = 0; r < 8; r++) check("rand_rf", rf[r], ref_rf[r]);

    // 6. reset while instructions are in flight
    ref_save = ref_rf;
    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'hAA, s);
    rst = 1'b1;
    instr_valid = 1'b1; opcode = 3'd7; rd = 3'd2; imm = 8'hBB;
    @(posedge clk);
    exp_q.delete();
    ref_rf = ref_save;
    issued = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    check("t6_we_in_rst", {31'h0, write_enable}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drain();
    check("t6_count", {16'h0, retired_count}, 32'h0);
    check("t6_r1_kept", rf[1], ref_rf[1]);
    check("t6_r2_kept", rf[2], ref_rf[2]);

    // counter wrap
    for (int i = 0; i < 65535; i++) begin
      issue(3'd7, 3'(i), 3'd0, 3'd0, 8'(i), s);
    end
    drain();
    check("wrap_ffff", {16'h0, retired_count}, 32'h0000FFFF);
    issue(3'd7, 3'd3, 3'd0, 3'd0, 8'h5A, s);
    drain();
    check("wrap_zero", {16'h0, retired_count}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
